// File: rtl/cr_input_pkg.sv
// Shared keycode, direction, player and FSM-state definitions for game input decoding.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package cr_input_pkg;

    // USB HID keycodes for the keys each player uses
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;

    // One-hot hop direction {up,down,left,right}; all zeros means no hop
    typedef logic [3:0] dir_t;
    localparam dir_t DIR_NONE  = 4'b0000;
    localparam dir_t DIR_UP    = 4'b1000;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b0010;
    localparam dir_t DIR_RIGHT = 4'b0001;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Decoded key; an invalid key is always normalised to all zeros so
    // that comparing two keys never sees stale player/dir bits.
    typedef struct packed {
        logic    valid;
        player_t player;
        dir_t    dir;
    } key_t;

    localparam key_t KEY_NONE = '{valid: 1'b0, player: PLAYER_1, dir: DIR_NONE};

endpackage

// File: rtl/cr_keycode_decode.sv
// Maps a raw HID keycode to {valid, player, dir}; unmapped codes decode to none.
// Latency: purely combinational.
// Backpressure: none.
module cr_keycode_decode
    import cr_input_pkg::*;
(
    input  logic [7:0] keycode,
    output logic       valid,
    output player_t    player,
    output dir_t       dir
);

    // Table lookup; default leaves the output all-zero for unmapped keys
    always_comb begin
        valid  = 1'b0;
        player = PLAYER_1;
        dir    = DIR_NONE;
        case (keycode)
            KC_W:     begin valid = 1'b1; player = PLAYER_1; dir = DIR_UP;    end
            KC_S:     begin valid = 1'b1; player = PLAYER_1; dir = DIR_DOWN;  end
            KC_A:     begin valid = 1'b1; player = PLAYER_1; dir = DIR_LEFT;  end
            KC_D:     begin valid = 1'b1; player = PLAYER_1; dir = DIR_RIGHT; end
            KC_UP:    begin valid = 1'b1; player = PLAYER_2; dir = DIR_UP;    end
            KC_DOWN:  begin valid = 1'b1; player = PLAYER_2; dir = DIR_DOWN;  end
            KC_LEFT:  begin valid = 1'b1; player = PLAYER_2; dir = DIR_LEFT;  end
            KC_RIGHT: begin valid = 1'b1; player = PLAYER_2; dir = DIR_RIGHT; end
            default:  begin valid = 1'b0; player = PLAYER_1; dir = DIR_NONE;  end
        endcase
    end

endmodule

// File: rtl/player_input_decoder.sv
// Turns the keycode into per-player one-hot hops with press-edge detect and frame-counted auto-repeat.
// Latency: outputs update one Clk after the vsync falling edge is sampled; hop pulses last one Clk.
// Backpressure: none; only the keycode present at each frame tick is observed.
module player_input_decoder
    import cr_input_pkg::*;
#(
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 6,
    parameter int CNT_W        = 6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       game_active,
    output logic [3:0] p1_dir,
    output logic [3:0] p2_dir,
    output logic       p1_hop,
    output logic       p2_hop
);

    // Counter reload values: the counter hits zero on the frame that should hop
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    logic             vs_q;
    logic             tick;
    logic             dec_valid;
    player_t          dec_player;
    dir_t             dec_dir;
    key_t             dec_key;
    key_t             held_key;
    key_t             held_key_nxt;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic             issue;
    dir_t             p1_dir_nxt;
    dir_t             p2_dir_nxt;
    logic             p1_hop_nxt;
    logic             p2_hop_nxt;

    cr_keycode_decode u_decode (
        .keycode (keycode),
        .valid   (dec_valid),
        .player  (dec_player),
        .dir     (dec_dir)
    );

    assign dec_key = {dec_valid, dec_player, dec_dir};

    // Delay vsync one Clk so its falling edge gives a single-cycle tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) vs_q <= 1'b1;
        else          vs_q <= frame_clk;
    end

    assign tick = vs_q & ~frame_clk;

    // Next-state and output decision for the coming tick; first matching rule wins
    always_comb begin
        state_nxt    = state;
        held_key_nxt = held_key;
        counter_nxt  = counter;
        issue        = 1'b0;
        p1_dir_nxt   = DIR_NONE;
        p2_dir_nxt   = DIR_NONE;
        p1_hop_nxt   = 1'b0;
        p2_hop_nxt   = 1'b0;

        if (!game_active || !dec_valid) begin
            state_nxt    = IDLE;
            held_key_nxt = KEY_NONE;
        end else if (dec_key != held_key || state == IDLE) begin
            issue        = 1'b1;
            held_key_nxt = dec_key;
            counter_nxt  = DELAY_LOAD;
            state_nxt    = DELAY;
        end else if (counter == '0) begin
            issue        = 1'b1;
            counter_nxt  = RATE_LOAD;
            state_nxt    = REPEAT;
        end else begin
            counter_nxt  = counter - 1'b1;
        end

        if (issue) begin
            if (dec_player == PLAYER_1) begin
                p1_dir_nxt = dec_dir;
                p1_hop_nxt = 1'b1;
            end else begin
                p2_dir_nxt = dec_dir;
                p2_hop_nxt = 1'b1;
            end
        end
    end

    // Commit state and outputs only on a tick; dir holds across the frame, hop is a pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            held_key <= KEY_NONE;
            counter  <= '0;
            p1_dir   <= DIR_NONE;
            p2_dir   <= DIR_NONE;
            p1_hop   <= 1'b0;
            p2_hop   <= 1'b0;
        end else begin
            p1_hop <= 1'b0;
            p2_hop <= 1'b0;
            if (tick) begin
                state    <= state_nxt;
                held_key <= held_key_nxt;
                counter  <= counter_nxt;
                p1_dir   <= p1_dir_nxt;
                p2_dir   <= p2_dir_nxt;
                p1_hop   <= p1_hop_nxt;
                p2_hop   <= p2_hop_nxt;
            end
        end
    end

endmodule

// File: tb/tb_player_input_decoder.sv
// Randomised and directed stimulus checked against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_player_input_decoder;

    localparam int RD = 12;
    localparam int RR = 6;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       game_active;
    logic [3:0] p1_dir;
    logic [3:0] p2_dir;
    logic       p1_hop;
    logic       p2_hop;

    int n_checks = 0;
    int n_errors = 0;
    int hop_cnt  = 0;

    // Reference model state: held key id (-1 = none) and ticks since press
    int m_held = -1;
    int m_age  = 0;

    player_input_decoder #(
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .CNT_W        (6)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .game_active (game_active),
        .p1_dir      (p1_dir),
        .p2_dir      (p2_dir),
        .p1_hop      (p1_hop),
        .p2_hop      (p2_hop)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Key id = player*16 + one-hot dir nibble, or -1 for no key
    function automatic int key_id(input logic [7:0] kc);
        case (kc)
            8'h1A:   return 8;
            8'h16:   return 4;
            8'h04:   return 2;
            8'h07:   return 1;
            8'h52:   return 16 + 8;
            8'h51:   return 16 + 4;
            8'h50:   return 16 + 2;
            8'h4F:   return 16 + 1;
            default: return -1;
        endcase
    endfunction

    // Hops happen on the press and then at ages RD, RD+RR, RD+2*RR, ...
    task automatic model_tick(output logic [3:0] e1, output logic [3:0] e2,
                              output logic eh1, output logic eh2);
        int  d;
        bit  hop;
        logic [4:0] dv;
        d   = key_id(keycode);
        hop = 1'b0;
        e1 = 4'h0; e2 = 4'h0; eh1 = 1'b0; eh2 = 1'b0;
        if (!game_active || d < 0) begin
            m_held = -1;
        end else if (d != m_held) begin
            m_held = d;
            m_age  = 0;
            hop    = 1'b1;
        end else begin
            m_age++;
            if (m_age == RD || (m_age > RD && ((m_age - RD) % RR) == 0)) hop = 1'b1;
        end
        if (hop) begin
            dv = d[4:0];
            if (d < 16) begin e1 = dv[3:0]; eh1 = 1'b1; end
            else        begin e2 = dv[3:0]; eh2 = 1'b1; end
        end
    endtask

    // One frame; optionally flash another keycode mid-frame, which must be invisible
    task automatic frame(input string tag, input bit glitch, input logic [7:0] gkc);
        logic [3:0] e1, e2;
        logic       eh1, eh2;
        logic [7:0] saved;
        if (glitch) begin
            saved = keycode;
            @(negedge Clk) keycode = gkc;
            repeat (2) @(negedge Clk);
            keycode = saved;
        end
        @(negedge Clk) frame_clk = 1'b0;
        model_tick(e1, e2, eh1, eh2);
        @(negedge Clk);
        chk({tag, "_p1dir"}, {28'd0, p1_dir}, {28'd0, e1});
        chk({tag, "_p2dir"}, {28'd0, p2_dir}, {28'd0, e2});
        chk({tag, "_p1hop"}, {31'd0, p1_hop}, {31'd0, eh1});
        chk({tag, "_p2hop"}, {31'd0, p2_hop}, {31'd0, eh2});
        if (p1_hop) hop_cnt++;
        if (p2_hop) hop_cnt++;
        @(negedge Clk);
        chk({tag, "_pulse"}, {30'd0, p1_hop, p2_hop}, 32'd0);
        chk({tag, "_hold"}, {24'd0, p1_dir, p2_dir}, {24'd0, e1, e2});
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    logic [7:0] pool [10] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h00, 8'h2C};

    initial begin
        Reset_n     = 1'b0;
        frame_clk   = 1'b1;
        keycode     = 8'h00;
        game_active = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_out", {22'd0, p1_dir, p2_dir, p1_hop, p2_hop}, 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Long hold of D: hops at ticks 1, 13, 19, 25 only
        keycode = 8'h07;
        hop_cnt = 0;
        for (int i = 0; i < 30; i++) frame("hold_d", 1'b0, 8'h00);
        chk("hold_d_hops", hop_cnt, 4);

        // P2 up held 3 frames then left: second key restarts the delay
        keycode = 8'h00;
        frame("gap", 1'b0, 8'h00);
        keycode = 8'h52;
        hop_cnt = 0;
        for (int i = 0; i < 3; i++) frame("p2_up", 1'b0, 8'h00);
        keycode = 8'h50;
        frame("p2_left", 1'b0, 8'h00);
        chk("p2_switch_hops", hop_cnt, 2);

        // W with a mid-frame release/re-press: still one continuous hold
        keycode = 8'h1A;
        hop_cnt = 0;
        for (int i = 0; i < 14; i++) frame("w_glitch", (i % 3) == 1, 8'h00);
        chk("w_glitch_hops", hop_cnt, 2);

        // Inactive game suppresses hops; enabling acts as a fresh press
        game_active = 1'b0;
        keycode     = 8'h16;
        hop_cnt     = 0;
        for (int i = 0; i < 3; i++) frame("inactive", 1'b0, 8'h00);
        chk("inactive_hops", hop_cnt, 0);
        game_active = 1'b1;
        frame("enable", 1'b0, 8'h00);
        chk("enable_dir", {28'd0, p1_dir}, 32'h4);

        // Unmapped key never hops
        keycode = 8'h2C;
        hop_cnt = 0;
        for (int i = 0; i < 5; i++) frame("unmapped", 1'b0, 8'h00);
        chk("unmapped_hops", hop_cnt, 0);

        // Reset mid-repeat clears outputs at once; first tick after is a new press
        keycode = 8'h1A;
        frame("pre_rst", 1'b0, 8'h00);
        @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1 chk("async_rst", {22'd0, p1_dir, p2_dir, p1_hop, p2_hop}, 32'd0);
        m_held = -1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        frame("post_rst", 1'b0, 8'h00);
        chk("post_rst_dir", {28'd0, p1_dir}, 32'h8);

        // Random runs of keys, enables and invisible mid-frame glitches
        for (int s = 0; s < 60; s++) begin
            keycode     = pool[$urandom_range(9, 0)];
            game_active = ($urandom_range(7, 0) != 0);
            for (int f = 0; f < int'($urandom_range(22, 1)); f++)
                frame("rand", ($urandom_range(3, 0) == 0), pool[$urandom_range(9, 0)]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
